// File: rtl/arm_fwd_pkg.sv
// arm_fwd_pkg: shared types and constants for the destination-tag forwarding pipeline
package arm_fwd_pkg;
  localparam int REG_W = 4;
  localparam int NREG = 2 ** REG_W;
  typedef struct packed {
    logic valid;
    logic wr;
    logic load;
    logic [REG_W-1:0] dst;
  } dst_tag_t;
  localparam dst_tag_t DST_BUBBLE = '0;
endpackage

// File: rtl/dst_stage_reg.sv
// dst_stage_reg: one pipeline stage of destination tags with sync clear and bubble select
module dst_stage_reg import arm_fwd_pkg::*; (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     bubble,
  input  dst_tag_t d,
  output dst_tag_t q
);
  always_ff @(posedge clk)
    q <= (!rst_n || bubble) ? DST_BUBBLE : d;
endmodule

// File: rtl/dst_tag_pipe.sv
// dst_tag_pipe: carries ID destination tags through EX/MEM/WB for forwarding, with per-register write scoreboard
module dst_tag_pipe #(
  parameter int REG_W = 4,
  parameter int NREG = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_wr,
  input  logic             id_load,
  input  logic             freeze,
  input  logic             flush,
  output logic [REG_W-1:0] match_add1,
  output logic [REG_W-1:0] match_add2,
  output logic [REG_W-1:0] match_add3,
  output logic             wr1,
  output logic             wr2,
  output logic             wr3,
  output logic             load,
  output logic [NREG-1:0]  busy,
  output logic [CNT_W-1:0] bubble_cnt
);
  import arm_fwd_pkg::*;
  dst_tag_t id_tag, ex, mem, wb;
  logic take;
  assign take = id_valid & ~freeze & ~flush;
  assign id_tag = '{valid: 1'b1, wr: id_wr, load: id_load, dst: id_dst};
  dst_stage_reg u_ex  (.clk(clk), .rst_n(rst_n), .bubble(~take), .d(id_tag), .q(ex));
  dst_stage_reg u_mem (.clk(clk), .rst_n(rst_n), .bubble(1'b0),  .d(ex),     .q(mem));
  dst_stage_reg u_wb  (.clk(clk), .rst_n(rst_n), .bubble(1'b0),  .d(mem),    .q(wb));
  // bubbles are all-zero, so the raw fields already read 0 whenever a stage is invalid
  assign match_add1 = ex.dst;
  assign match_add2 = mem.dst;
  assign match_add3 = wb.dst;
  assign wr1 = ex.wr;
  assign wr2 = mem.wr;
  assign wr3 = wb.wr;
  assign load = ex.load;
  always_ff @(posedge clk)
    bubble_cnt <= !rst_n ? '0 : bubble_cnt + CNT_W'((freeze | flush) & ~&bubble_cnt);
  for (genvar i = 0; i < NREG; i++) begin : g_sb
    logic inc, dec;
    logic [1:0] cnt;
    assign inc = take & id_wr & (id_dst == REG_W'(i));
    assign dec = wb.wr & (wb.dst == REG_W'(i));
    always_ff @(posedge clk)
      cnt <= !rst_n ? 2'd0 : cnt + 2'(inc) - 2'(dec);
    assign busy[i] = |cnt;
    a_no_ovf: assert property (@(posedge clk) disable iff (!rst_n) !(inc && !dec && cnt == 2'd3));
    a_no_udf: assert property (@(posedge clk) disable iff (!rst_n) !(dec && !inc && cnt == 2'd0));
  end
endmodule

// File: tb/tb_dst_tag_pipe.sv
// tb_dst_tag_pipe: scoreboard bench comparing dst_tag_pipe against an in-flight instruction list model
module tb_dst_tag_pipe;
  localparam int CW = 8;
  logic clk = 0, rst_n = 0, id_valid = 0, id_wr = 0, id_load = 0, freeze = 0, flush = 0;
  logic [3:0] id_dst = 0;
  logic [3:0] match_add1, match_add2, match_add3;
  logic wr1, wr2, wr3, load;
  logic [15:0] busy;
  logic [CW-1:0] bubble_cnt;
  int checks = 0, errors = 0;

  dst_tag_pipe #(.REG_W(4), .NREG(16), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_dst(id_dst), .id_wr(id_wr),
    .id_load(id_load), .freeze(freeze), .flush(flush), .match_add1(match_add1),
    .match_add2(match_add2), .match_add3(match_add3), .wr1(wr1), .wr2(wr2), .wr3(wr3),
    .load(load), .busy(busy), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { bit v; bit w; bit l; int d; } ins_t;
  typedef struct { int ma1, ma2, ma3; bit wr1, wr2, wr3, ld; logic [15:0] busy; int bc; } exp_t;
  ins_t inflight [3];
  int bc_model = 0;
  exp_t sb [$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, act, req, $time);
    end
  endtask

  // Model: list of instructions in EX, MEM, WB; busy = any listed writer targets r
  task automatic step(input bit v, input int d, input bit w, input bit l,
                      input bit frz, input bit fl, input bit rn);
    exp_t e;
    id_valid = v; id_dst = 4'(d); id_wr = w; id_load = l; freeze = frz; flush = fl; rst_n = rn;
    if (!rn) begin
      foreach (inflight[k]) inflight[k] = '{0, 0, 0, 0};
      bc_model = 0;
    end else begin
      inflight[2] = inflight[1];
      inflight[1] = inflight[0];
      inflight[0] = (v && !frz && !fl) ? '{1, w, l, d} : '{0, 0, 0, 0};
      if ((frz || fl) && bc_model < (1 << CW) - 1) bc_model++;
    end
    e.ma1 = inflight[0].v ? inflight[0].d : 0;
    e.ma2 = inflight[1].v ? inflight[1].d : 0;
    e.ma3 = inflight[2].v ? inflight[2].d : 0;
    e.wr1 = inflight[0].v && inflight[0].w;
    e.wr2 = inflight[1].v && inflight[1].w;
    e.wr3 = inflight[2].v && inflight[2].w;
    e.ld = inflight[0].v && inflight[0].l;
    e.busy = '0;
    foreach (inflight[k]) if (inflight[k].v && inflight[k].w) e.busy[inflight[k].d] = 1'b1;
    e.bc = bc_model;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("match_add1", 32'(match_add1), 32'(e.ma1));
        chk("match_add2", 32'(match_add2), 32'(e.ma2));
        chk("match_add3", 32'(match_add3), 32'(e.ma3));
        chk("wr1", 32'(wr1), 32'(e.wr1));
        chk("wr2", 32'(wr2), 32'(e.wr2));
        chk("wr3", 32'(wr3), 32'(e.wr3));
        chk("load", 32'(load), 32'(e.ld));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("bubble_cnt", 32'(bubble_cnt), 32'(e.bc));
      end
    end
  end

  initial begin : driver
    bit frz;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 5, 1, 0, 0, 0, 1);
    step(1, 8, 0, 0, 0, 0, 1);
    step(1, 10, 1, 0, 0, 0, 1);
    chk("seq_match_add1", 32'(match_add1), 32'd10);
    chk("seq_match_add3", 32'(match_add3), 32'd5);
    idle(3);
    step(1, 9, 1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    chk("load_bubble_match_add2", 32'(match_add2), 32'd9);
    idle(4);
    step(1, 7, 1, 0, 0, 0, 1);
    step(1, 7, 1, 0, 0, 0, 1);
    step(1, 7, 1, 0, 0, 0, 1);
    idle(5);
    step(1, 3, 1, 0, 1, 1, 1);
    idle(3);
    step(1, 4, 1, 0, 0, 0, 1);
    step(1, 5, 1, 0, 0, 0, 1);
    step(1, 6, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("reset_busy", 32'(busy), 32'd0);
    step(1, 4, 1, 0, 0, 0, 1);
    idle(4);
    for (int i = 0; i < 500; i++) begin
      frz = (load === 1'b1) || ($urandom_range(0, 5) == 0);
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), 1'($urandom),
           1'($urandom), frz, $urandom_range(0, 7) == 0, $urandom_range(0, 60) != 0);
    end
    for (int i = 0; i < (1 << CW) + 2; i++) step(1'($urandom), 2, 1, 0, 1, 0, 1);
    chk("bubble_cnt_saturated", 32'(bubble_cnt), 32'((1 << CW) - 1));
    idle(2);
    step(0, 0, 0, 0, 0, 0, 0);
    idle(2);
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
